// File: rtl/mem_bus_arbiter.sv
// Arbitrates CPU and DMA onto one asynchronous 8-bit memory bus and sequences a fixed-length ce_n/oe_n/we_n access.
// Build option MEM_ARB_RR_EN: round-robin contested arbitration instead of CPU priority with a starvation guard.
module mem_bus_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int ACC_CYCLES   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_rnw,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          dma_owner,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n
);

  // Handshake: a requester holds req with rnw/addr/wdata stable until its ack; ack is a
  // one-cycle pulse in RELEASE, and a req still high in the following IDLE is a new access.

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          rnw_q, rnw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic          grant_dma;
  logic          start;

  assign start = (state_q == ST_IDLE) && (cpu_req || dma_req);

`ifdef MEM_ARB_RR_EN
  // prio_dma_q names the side that wins the next contested arbitration.
  logic prio_dma_q, prio_dma_d;

  always_comb begin
    grant_dma  = dma_req && (!cpu_req || prio_dma_q);
    prio_dma_d = prio_dma_q;
    if (start) prio_dma_d = !grant_dma;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_dma_q <= 1'b0;
    else     prio_dma_q <= prio_dma_d;
  end
`else
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT_V = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;
  logic          starve_hit;

  always_comb begin
    starve_hit = (STARVE_LIMIT != 0) && (starve_q == LIMIT_V);
    grant_dma  = dma_req && (!cpu_req || starve_hit);
    starve_d   = starve_q;
    if (start) begin
      if (grant_dma)                                starve_d = '0;
      else if (cpu_req && dma_req && starve_q != '1) starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCESS;
          cnt_d   = CW'(ACC_CYCLES - 1);
          owner_d = grant_dma;
          rnw_d   = grant_dma ? dma_rnw   : cpu_rnw;
          addr_d  = grant_dma ? dma_addr  : cpu_addr;
          wdata_d = grant_dma ? dma_wdata : cpu_wdata;
          ce_n_d  = 1'b0;
          oe_n_d  = !rnw_d;
          we_n_d  = rnw_d;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (rnw_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          if (owner_q) dma_ack_d = 1'b1;
          else         cpu_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      rnw_q       <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign dma_owner = owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random CPU/DMA traffic against a
// transaction-level model (grant rules, per-access strobe counts, memory contents).
module tb_mem_bus_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int ACC = 2;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_rnw = 1'b1;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          dma_req = 1'b0, dma_rnw = 1'b1;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack, dma_owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ce_n, mem_oe_n, mem_we_n;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .ACC_CYCLES(ACC), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_owner(dma_owner),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model; writes land mid-cycle while ce_n/we_n are low.
  logic [7:0] mem_arr [0:65535];
  logic [7:0] exp_mem [0:65535];
  assign mem_rdata = mem_arr[mem_addr];
  always @(negedge clk) if (!mem_ce_n && !mem_we_n) mem_arr[mem_addr] = mem_wdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester model: pending transaction per side
  bit         c_pend = 0, d_pend = 0;
  logic       c_rnw = 1, d_rnw = 1;
  logic [15:0] c_addr = 0, d_addr = 0;
  logic [7:0]  c_wd = 0, d_wd = 0;
  logic [7:0]  exp_cpu_rd = 0, exp_dma_rd = 0;
  int          starve_cnt = 0;
  bit          rr_dma_next = 0;
  bit          after_ack = 0;
  bit          win;
  logic [7:0]  t6_vals [3];

  task automatic drive_reqs();
    cpu_req = c_pend; cpu_rnw = c_rnw; cpu_addr = c_addr; cpu_wdata = c_wd;
    dma_req = d_pend; dma_rnw = d_rnw; dma_addr = d_addr; dma_wdata = d_wd;
  endtask

  task automatic gen_cpu();
    if (!c_pend) begin
      c_pend = 1; c_rnw = 1'($urandom_range(0, 1));
      c_addr = 16'($urandom_range(0, 65535)); c_wd = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic gen_dma();
    if (!d_pend) begin
      d_pend = 1; d_rnw = 1'($urandom_range(0, 1));
      d_addr = 16'($urandom_range(0, 65535)); d_wd = 8'($urandom_range(0, 255));
    end
  endtask

  // Grant rule applied to whoever is pending when the bus is next free.
  task automatic model_pick(output bit w);
    if (c_pend && !d_pend)      w = 0;
    else if (!c_pend && d_pend) w = 1;
    else begin
`ifdef MEM_ARB_RR_EN
      w = rr_dma_next;
`else
      w = (LIM != 0) && (starve_cnt == LIM);
`endif
    end
`ifdef MEM_ARB_RR_EN
    rr_dma_next = !w;
`else
    if (w) starve_cnt = 0;
    else if (c_pend && d_pend && starve_cnt < LIM) starve_cnt++;
`endif
  endtask

  // One complete bus transaction for the model-chosen winner, observed after each edge.
  task automatic round(output bit w);
    logic        rnw;
    logic [15:0] a;
    logic [7:0]  wd;
    int          lat, edges, ce, oe, we;
    bit          got, bus_ok;
    model_pick(w);
    drive_reqs();
    rnw = w ? d_rnw : c_rnw;
    a   = w ? d_addr : c_addr;
    wd  = w ? d_wd : c_wd;
    lat = after_ack ? ACC + 2 : ACC + 1;
    edges = 0; ce = 0; oe = 0; we = 0; got = 0; bus_ok = 1;
    while (!got && edges < 4 * ACC + 10) begin
      @(posedge clk); #1;
      edges++;
      if (!mem_ce_n) begin
        ce++;
        if (!mem_oe_n) oe++;
        if (!mem_we_n) we++;
        if (mem_addr !== a || (!rnw && mem_wdata !== wd) || dma_owner !== w) bus_ok = 0;
      end
      if (cpu_ack || dma_ack) got = 1;
    end
    check("ack_seen", got, 1);
    check("latency", edges, lat);
    check("ce_low_cycles", ce, ACC);
    check("oe_low_cycles", oe, rnw ? ACC : 0);
    check("we_low_cycles", we, rnw ? 0 : ACC);
    check("bus_stable", bus_ok, 1);
    check("cpu_ack", cpu_ack, !w);
    check("dma_ack", dma_ack, w);
    check("dma_owner", dma_owner, w);
    check("release_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    check("release_addr", mem_addr, a);
    if (rnw) begin
      if (w) exp_dma_rd = exp_mem[a];
      else   exp_cpu_rd = exp_mem[a];
    end else begin
      check("release_wdata", mem_wdata, wd);
      exp_mem[a] = wd;
    end
    check("cpu_rdata", cpu_rdata, exp_cpu_rd);
    check("dma_rdata", dma_rdata, exp_dma_rd);
    if (w) d_pend = 0;
    else   c_pend = 0;
    drive_reqs();
    after_ack = got;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_bus", {mem_ce_n, cpu_ack, dma_ack}, 3'b100);
    end
    after_ack = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 8'($urandom_range(0, 255));
      exp_mem[i] = mem_arr[i];
    end
    t6_vals[0] = 8'h21; t6_vals[1] = 8'h55; t6_vals[2] = 8'hAA;

    // Reset values
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    check("rst_acks", {cpu_ack, dma_ack}, 0);
    check("rst_owner", dma_owner, 0);
    rst = 0;
    after_ack = 0;

    // CPU read of 0x0000 returning 0x21
    mem_arr[0] = 8'h21; exp_mem[0] = 8'h21;
    c_pend = 1; c_rnw = 1; c_addr = 16'h0000; c_wd = 8'h00;
    round(win);
    check("t1_rdata", cpu_rdata, 8'h21);
    idle(1);

    // DMA write 0x8001 <= 0x55
    d_pend = 1; d_rnw = 0; d_addr = 16'h8001; d_wd = 8'h55;
    round(win);
    check("t2_mem", mem_arr[16'h8001], 8'h55);
    idle(1);

    // Both requesters held high: grant order
    for (int k = 0; k < 10; k++) begin
      gen_cpu(); gen_dma();
      round(win);
`ifdef MEM_ARB_RR_EN
      check("t3_order", win, (k % 2) == 1);
`else
      check("t3_order", win, (k % 5) == 4);
`endif
    end

    // Random mixed traffic
    for (int k = 0; k < 60; k++) begin
      int r;
      if (!c_pend && !d_pend && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      r = $urandom_range(0, 3);
      if (r == 1 || r == 3) gen_cpu();
      if (r == 2 || r == 3) gen_dma();
      if (!c_pend && !d_pend) begin
        if ($urandom_range(0, 1) == 1) gen_cpu();
        else gen_dma();
      end
      round(win);
    end
    while (c_pend || d_pend) round(win);
    idle(2);

    // Back-to-back CPU reads 0x0000..0x0002
    for (int k = 0; k < 3; k++) begin
      mem_arr[k] = t6_vals[k]; exp_mem[k] = t6_vals[k];
    end
    for (int k = 0; k < 3; k++) begin
      c_pend = 1; c_rnw = 1; c_addr = 16'(k); c_wd = 8'h00;
      round(win);
      check("t6_rdata", cpu_rdata, t6_vals[k]);
    end
    idle(1);

    // Reset during the first ACCESS cycle of a DMA write, then clean restart
    d_pend = 1; d_rnw = 0; d_addr = 16'h1234; d_wd = 8'($urandom_range(0, 255));
    drive_reqs();
    @(posedge clk); #1;
    check("t5_we_low", {mem_ce_n, mem_we_n}, 2'b00);
    rst = 1;
    @(posedge clk); #1;
    check("t5_rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    check("t5_rst_acks", {cpu_ack, dma_ack}, 0);
    check("t5_rst_owner", dma_owner, 0);
    rst = 0;
    starve_cnt = 0; rr_dma_next = 0; after_ack = 0;
    exp_cpu_rd = 0; exp_dma_rd = 0;
    round(win);
    check("t5_mem", mem_arr[16'h1234], d_wd);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
